mc_ctrl: RTL and testbench
==========================

// Module: mc_ctrl
// PURPOSE
//  Multi-cycle control FSM for the MIPS core, sequencing the shared ALU, register file, NPC and a single
//  instruction/data memory port over IF/ID/EX/MEM/WB states. Takes Op/Funct from the IR register and
//  Zero from the ALU, and emits per-state enables plus a req/ack memory handshake with timeout.
//  Supports add,sub,and,or,slt,sltu,addu,subu,sll,srl,sllv,srlv,nor,jr,jalr,addi,andi,ori,slti,lui,lw,sw,beq,bne,j,jal.
// PARAMETERS
//  MEM_WAIT_MAX  15  max cycles mem_req may stay high without mem_ack before timeout (1..255)
//  CNT_W         32  width of retired-instruction counter
// PORTS
//  clk       in   1      clock, all state on rising edge
//  rst       in   1      synchronous, active-high reset
//  Op        in   6      opcode from IR
//  Funct     in   6      funct from IR
//  Zero      in   1      ALU zero flag (valid in S_EX)
//  mem_ack   in   1      memory completes the current request this cycle
//  mem_req   out  1      memory request (fetch in S_IF, data access in S_MEM)
//  MemWrite  out  1      request is a store (only with mem_req in S_MEM)
//  IRWrite   out  1      load IR from memory read data
//  PCWrite   out  1      load PC from NPC (exactly once per retired instruction)
//  RegWrite  out  1      register file write
//  EXTOp     out  2      01 sign, 10 lui, 00 zero
//  ALUOp     out  4      0 NOP,1 ADD,2 SUB,3 AND,4 OR,5 SLT,6 SLTU,7 NOR,8 SLL,9 SRL
//  ALUSrc    out  2      [1] B=imm, [0] A=shamt
//  NPCOp     out  2      00 PC+4, 01 branch, 10 jump, 11 jump-reg
//  GPRSel    out  2      00 rd, 01 rt, 10 r31
//  WDSel     out  2      00 ALU, 01 MEM, 10 PC+4 (of unupdated PC)
//  state_o   out  3      current state encoding
//  illegal   out  1      sticky: unsupported Op/Funct decoded
//  timeout   out  1      sticky: memory handshake timeout
//  instr_cnt out  CNT_W  retired-instruction count, wraps to 0
// BEHAVIOUR
//  States: S_IF=0,S_ID=1,S_EX=2,S_MEM=3,S_WB=4,S_ERR=5. Outputs combinational from state+Op/Funct/Zero.
//  Reset: state=S_IF, wait_cnt=0, instr_cnt=0, illegal=timeout=0; while rst=1 all enables and mem_req forced 0.
//  PC held through the instruction; PCWrite only in the final state; instr_cnt += 1 on that same edge.
//  S_IF: mem_req=1; on mem_ack: IRWrite=1 -> S_ID; else stay.
//  S_ID: unsupported -> S_ERR (illegal=1). j: PCWrite,NPCOp=10 -> S_IF. jal: also RegWrite,GPRSel=10,WDSel=10.
//        all others -> S_EX. No write enables otherwise.
//  S_EX: ALUOp/ALUSrc/EXTOp per instruction (lw/sw/addi ADD sign-ext; beq/bne SUB; andi/ori zero-ext).
//        beq/bne: PCWrite, NPCOp=01 if (beq&Zero)|(bne&~Zero) else 00 -> S_IF.
//        jr: PCWrite,NPCOp=11 -> S_IF. jalr: same + RegWrite,GPRSel=00,WDSel=10.
//        lw/sw -> S_MEM; other ALU ops -> S_WB.
//  S_MEM: ALU ctrl held as S_EX (address stable); mem_req=1, MemWrite=sw. On ack: sw PCWrite,NPCOp=00 -> S_IF;
//         lw -> S_WB (read data latched externally on ack).
//  S_WB: RegWrite=1, PCWrite=1, NPCOp=00; lw: WDSel=01,GPRSel=01; I-type ALU GPRSel=01; R-type 00 -> S_IF.
//  Timeout: wait_cnt counts cycles with mem_req=1 & ~mem_ack, cleared on ack or leaving state.
//        wait_cnt==MEM_WAIT_MAX-1 and no ack -> S_ERR, timeout=1. Ack on that same cycle wins (no error).
//  S_ERR: all enables 0, mem_req=0; stays until rst. instr_cnt frozen.
//  Reset mid-instruction: abandon instruction, no PCWrite/RegWrite on the reset edge; restart in S_IF.
//  CPI: j/jal 2, branch/jr/jalr 3, ALU 4, sw 4, lw 5 (each mem access +N ack-wait cycles).
// TESTING
//  addi $1,$0,5 (Op=001000), mem_ack same cycle -> IF,ID,EX,WB; WB: RegWrite=1,GPRSel=01,ALUOp=1; instr_cnt=1.
//  lw with data ack delayed 3 cycles -> S_MEM held 4 cycles, mem_req=1,MemWrite=0; WB WDSel=01; total 8 cycles.
//  beq Zero=1 -> EX PCWrite=1,NPCOp=01; bne Zero=1 -> NPCOp=00; both return to S_IF next cycle.
//  jal -> ID RegWrite=1,GPRSel=10,WDSel=10,NPCOp=10; jalr in EX -> NPCOp=11,WDSel=10,GPRSel=00.
//  Op=111111 -> S_ERR, illegal=1, no PCWrite; held until rst; mem_ack never asserted 15 cycles in IF -> timeout=1.
//  rst asserted in S_MEM of sw -> MemWrite/mem_req 0 that cycle; next cycle state=S_IF, instr_cnt=0.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences IF/ID/EX/MEM/WB over a shared ALU and a single
// req/ack memory port, with sticky illegal-instruction and memory-timeout error capture.
module mc_ctrl #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       Op,
    input  logic [5:0]       Funct,
    input  logic             Zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic [1:0]       EXTOp,
    output logic [3:0]       ALUOp,
    output logic [1:0]       ALUSrc,
    output logic [1:0]       NPCOp,
    output logic [1:0]       GPRSel,
    output logic [1:0]       WDSel,
    output logic [2:0]       state_o,
    output logic             illegal,
    output logic             timeout,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_ERR = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        K_R_ALU, K_I_ALU, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_JR, K_JALR, K_BAD
    } kind_t;

    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_NOR  = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    localparam logic [1:0] SRC_REG   = 2'b00;
    localparam logic [1:0] SRC_SHAMT = 2'b01;
    localparam logic [1:0] SRC_IMM   = 2'b10;

    localparam logic [1:0] NPC_SEQ  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_JMP  = 2'b10;
    localparam logic [1:0] NPC_JREG = 2'b11;

    localparam logic [1:0] GPR_RD  = 2'b00;
    localparam logic [1:0] GPR_RT  = 2'b01;
    localparam logic [1:0] GPR_R31 = 2'b10;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC4 = 2'b10;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    state_t     state, state_n;
    kind_t      kind;
    logic [3:0] dec_alu;
    logic [1:0] dec_src;
    logic [1:0] dec_ext;
    logic [7:0] wait_cnt;
    logic       wait_last;
    logic       set_illegal;
    logic       set_timeout;

    // NOTE: every always_comb output gets a default before any branch, so no path leaves a latch.
    always_comb begin
        kind    = K_BAD;
        dec_alu = ALU_NOP;
        dec_src = SRC_REG;
        dec_ext = EXT_ZERO;
        case (Op)
            6'b000000: begin
                case (Funct)
                    6'b100000, 6'b100001: begin kind = K_R_ALU; dec_alu = ALU_ADD;  end
                    6'b100010, 6'b100011: begin kind = K_R_ALU; dec_alu = ALU_SUB;  end
                    6'b100100:            begin kind = K_R_ALU; dec_alu = ALU_AND;  end
                    6'b100101:            begin kind = K_R_ALU; dec_alu = ALU_OR;   end
                    6'b100111:            begin kind = K_R_ALU; dec_alu = ALU_NOR;  end
                    6'b101010:            begin kind = K_R_ALU; dec_alu = ALU_SLT;  end
                    6'b101011:            begin kind = K_R_ALU; dec_alu = ALU_SLTU; end
                    6'b000000: begin kind = K_R_ALU; dec_alu = ALU_SLL; dec_src = SRC_SHAMT; end
                    6'b000010: begin kind = K_R_ALU; dec_alu = ALU_SRL; dec_src = SRC_SHAMT; end
                    6'b000100:            begin kind = K_R_ALU; dec_alu = ALU_SLL;  end
                    6'b000110:            begin kind = K_R_ALU; dec_alu = ALU_SRL;  end
                    6'b001000:            kind = K_JR;
                    6'b001001:            kind = K_JALR;
                    default:              kind = K_BAD;
                endcase
            end
            6'b001000: begin kind = K_I_ALU; dec_alu = ALU_ADD; dec_src = SRC_IMM; dec_ext = EXT_SIGN; end
            6'b001100: begin kind = K_I_ALU; dec_alu = ALU_AND; dec_src = SRC_IMM; dec_ext = EXT_ZERO; end
            6'b001101: begin kind = K_I_ALU; dec_alu = ALU_OR;  dec_src = SRC_IMM; dec_ext = EXT_ZERO; end
            6'b001010: begin kind = K_I_ALU; dec_alu = ALU_SLT; dec_src = SRC_IMM; dec_ext = EXT_SIGN; end
            6'b001111: begin kind = K_I_ALU; dec_alu = ALU_ADD; dec_src = SRC_IMM; dec_ext = EXT_LUI;  end
            6'b100011: begin kind = K_LW;    dec_alu = ALU_ADD; dec_src = SRC_IMM; dec_ext = EXT_SIGN; end
            6'b101011: begin kind = K_SW;    dec_alu = ALU_ADD; dec_src = SRC_IMM; dec_ext = EXT_SIGN; end
            6'b000100: begin kind = K_BEQ;   dec_alu = ALU_SUB; dec_ext = EXT_SIGN; end
            6'b000101: begin kind = K_BNE;   dec_alu = ALU_SUB; dec_ext = EXT_SIGN; end
            6'b000010: kind = K_J;
            6'b000011: kind = K_JAL;
            default:   kind = K_BAD;
        endcase
    end

    assign wait_last = (wait_cnt == WAIT_LAST);

    always_comb begin
        state_n     = state;
        mem_req     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        RegWrite    = 1'b0;
        EXTOp       = EXT_ZERO;
        ALUOp       = ALU_NOP;
        ALUSrc      = SRC_REG;
        NPCOp       = NPC_SEQ;
        GPRSel      = GPR_RD;
        WDSel       = WD_ALU;
        set_illegal = 1'b0;
        set_timeout = 1'b0;

        // ALU controls stay valid from EX through WB so the address/result never glitches.
        if (state inside {S_EX, S_MEM, S_WB}) begin
            ALUOp  = dec_alu;
            ALUSrc = dec_src;
            EXTOp  = dec_ext;
        end

        case (state)
            S_IF: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    IRWrite = 1'b1;
                    state_n = S_ID;
                end else if (wait_last) begin
                    set_timeout = 1'b1;
                    state_n     = S_ERR;
                end
            end
            S_ID: begin
                case (kind)
                    K_BAD: begin
                        set_illegal = 1'b1;
                        state_n     = S_ERR;
                    end
                    K_J: begin
                        PCWrite = 1'b1;
                        NPCOp   = NPC_JMP;
                        state_n = S_IF;
                    end
                    K_JAL: begin
                        PCWrite  = 1'b1;
                        NPCOp    = NPC_JMP;
                        RegWrite = 1'b1;
                        GPRSel   = GPR_R31;
                        WDSel    = WD_PC4;
                        state_n  = S_IF;
                    end
                    default: state_n = S_EX;
                endcase
            end
            S_EX: begin
                case (kind)
                    K_BEQ, K_BNE: begin
                        PCWrite = 1'b1;
                        if ((kind == K_BEQ && Zero) || (kind == K_BNE && !Zero))
                            NPCOp = NPC_BR;
                        state_n = S_IF;
                    end
                    K_JR: begin
                        PCWrite = 1'b1;
                        NPCOp   = NPC_JREG;
                        state_n = S_IF;
                    end
                    K_JALR: begin
                        PCWrite  = 1'b1;
                        NPCOp    = NPC_JREG;
                        RegWrite = 1'b1;
                        GPRSel   = GPR_RD;
                        WDSel    = WD_PC4;
                        state_n  = S_IF;
                    end
                    K_LW, K_SW: state_n = S_MEM;
                    default:    state_n = S_WB;
                endcase
            end
            S_MEM: begin
                mem_req  = 1'b1;
                MemWrite = (kind == K_SW);
                if (mem_ack) begin
                    if (kind == K_SW) begin
                        PCWrite = 1'b1;
                        state_n = S_IF;
                    end else begin
                        state_n = S_WB;
                    end
                end else if (wait_last) begin
                    set_timeout = 1'b1;
                    state_n     = S_ERR;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
                GPRSel   = (kind == K_I_ALU || kind == K_LW) ? GPR_RT : GPR_RD;
                WDSel    = (kind == K_LW) ? WD_MEM : WD_ALU;
                state_n  = S_IF;
            end
            S_ERR:   state_n = S_ERR;
            default: state_n = S_ERR;
        endcase

        // Reset abandons the instruction: nothing may commit on the reset edge.
        if (rst) begin
            mem_req     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            PCWrite     = 1'b0;
            RegWrite    = 1'b0;
            set_illegal = 1'b0;
            set_timeout = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IF;
            wait_cnt  <= '0;
            instr_cnt <= '0;
            illegal   <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            wait_cnt  <= (mem_req && !mem_ack) ? wait_cnt + 8'd1 : 8'd0;
            if (PCWrite)
                instr_cnt <= instr_cnt + 1'b1;
            if (set_illegal)
                illegal <= 1'b1;
            if (set_timeout)
                timeout <= 1'b1;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized bench for mc_ctrl: an instruction-level model expands each instruction into its
// expected per-cycle state/control trace, with random memory wait lengths and error scenarios.
module tb_mc_ctrl;

    localparam int WMAX = 15;
    localparam int CW   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    Op, Funct;
    logic          Zero, mem_ack;
    logic          mem_req, MemWrite, IRWrite, PCWrite, RegWrite;
    logic [1:0]    EXTOp, ALUSrc, NPCOp, GPRSel, WDSel;
    logic [3:0]    ALUOp;
    logic [2:0]    state_o;
    logic          illegal, timeout;
    logic [CW-1:0] instr_cnt;

    mc_ctrl #(.MEM_WAIT_MAX(WMAX), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_ack(mem_ack),
        .mem_req(mem_req), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .RegWrite(RegWrite), .EXTOp(EXTOp), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .NPCOp(NPCOp),
        .GPRSel(GPRSel), .WDSel(WDSel), .state_o(state_o), .illegal(illegal),
        .timeout(timeout), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    typedef enum int {R_ALU, I_ALU, LW, SW, BEQ, BNE, J, JAL, JR, JALR} kind_e;
    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        kind_e      k;
        logic [3:0] alu;
        logic [1:0] src;
        logic [1:0] ext;
    } ins_t;

    localparam int IX_ADD = 0, IX_JR = 13, IX_JALR = 14, IX_ADDI = 15, IX_LW = 20, IX_SW = 21;
    localparam int IX_BEQ = 22, IX_BNE = 23, IX_J = 24, IX_JAL = 25;

    ins_t       tab[$];
    int         n_vec = 0;
    int         n_bad = 0;
    int         n_ret = 0;
    logic [5:0] cur_op = '0, cur_fn = '0;
    logic       cur_z = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (Op=%0h Funct=%0h t=%0t)",
                     tag, got, exp, cur_op, cur_fn, $time);
        end
    endtask

    task automatic add_ins(input logic [5:0] op, input logic [5:0] fn, input kind_e k,
                           input logic [3:0] alu, input logic [1:0] src, input logic [1:0] ext);
        ins_t e;
        e.op = op; e.fn = fn; e.k = k; e.alu = alu; e.src = src; e.ext = ext;
        tab.push_back(e);
    endtask

    // Layout: req mw irw pcw rw | ext alu src | npc | gsel wsel
    function automatic logic [18:0] pk(input logic req, input logic mw, input logic irw,
                                       input logic pcw, input logic rw, input logic [1:0] ext,
                                       input logic [3:0] alu, input logic [1:0] src,
                                       input logic [1:0] npc, input logic [1:0] gs,
                                       input logic [1:0] ws);
        return {req, mw, irw, pcw, rw, ext, alu, src, npc, gs, ws};
    endfunction

    // One clock: drive on the falling edge, sample 1ns later. Fields that carry no meaning
    // (ALU controls outside EX..WB, NPC without PCWrite, write selects without RegWrite) are masked.
    task automatic step(input logic ack, input logic [2:0] st, input logic [18:0] exp,
                        input string tag);
        logic [18:0] got, mask;
        @(negedge clk);
        Op = cur_op; Funct = cur_fn; Zero = cur_z; mem_ack = ack;
        #1;
        got  = {mem_req, MemWrite, IRWrite, PCWrite, RegWrite, EXTOp, ALUOp, ALUSrc,
                NPCOp, GPRSel, WDSel};
        mask = 19'h7C000;
        if (st inside {3'd2, 3'd3, 3'd4}) mask |= 19'h03FC0;
        if (exp[15]) mask |= 19'h00030;
        if (exp[14]) mask |= 19'h0000F;
        check({tag, "/state"}, 32'(state_o), 32'(st));
        check({tag, "/ctl"}, 32'(got & mask), 32'(exp & mask));
    endtask

    task automatic do_reset(input logic [2:0] st_now);
        @(negedge clk);
        rst = 1'b1; mem_ack = 1'b0;
        #1;
        check("rst_state", 32'(state_o), 32'(st_now));
        check("rst_enables", 32'({mem_req, MemWrite, IRWrite, PCWrite, RegWrite}), 32'd0);
        @(posedge clk);
        #1;
        check("post_rst_state", 32'(state_o), 32'd0);
        check("post_rst_cnt", 32'(instr_cnt), 32'd0);
        check("post_rst_flags", 32'({illegal, timeout}), 32'd0);
        rst   = 1'b0;
        n_ret = 0;
    endtask

    task automatic err_hold(input logic exp_ill, input logic exp_to);
        logic [CW-1:0] cnt_exp;
        cnt_exp = n_ret[CW-1:0];
        for (int i = 0; i < 4; i++) step(1'b0, 3'd5, 19'd0, "err");
        check("err_flags", 32'({illegal, timeout}), 32'({exp_ill, exp_to}));
        check("err_cnt_frozen", 32'(instr_cnt), 32'(cnt_exp));
    endtask

    // d_if / d_mem: ack-wait cycles; WMAX or more means the memory never answers.
    task automatic run_instr(input int idx, input logic z, input int d_if, input int d_mem,
                             input bit abort_mem);
        ins_t        e;
        logic        taken, last, is_sw;
        logic [1:0]  gs, ws;
        int          n_cyc;
        e      = tab[idx];
        cur_op = e.op;
        cur_fn = (e.op == 6'd0) ? e.fn : 6'($urandom);
        cur_z  = z;
        is_sw  = (e.k == SW);

        n_cyc = (d_if < WMAX) ? d_if + 1 : WMAX;
        for (int c = 0; c < n_cyc; c++) begin
            last = (d_if < WMAX) && (c == d_if);
            step(last, 3'd0, pk(1, 0, last, 0, 0, 0, 0, 0, 0, 0, 0), "if");
            if (c == 0) begin
                check("instr_cnt", 32'(instr_cnt), 32'(n_ret[CW-1:0]));
                check("flags", 32'({illegal, timeout}), 32'd0);
            end
        end
        if (d_if >= WMAX) begin
            err_hold(1'b0, 1'b1);
            return;
        end

        if (e.k == J) begin
            step(1'b0, 3'd1, pk(0, 0, 0, 1, 0, 0, 0, 0, 2'b10, 0, 0), "id_j");
            n_ret++;
            return;
        end
        if (e.k == JAL) begin
            step(1'b0, 3'd1, pk(0, 0, 0, 1, 1, 0, 0, 0, 2'b10, 2'b10, 2'b10), "id_jal");
            n_ret++;
            return;
        end
        step(1'b0, 3'd1, 19'd0, "id");

        if (e.k == BEQ || e.k == BNE) begin
            taken = (e.k == BEQ) ? z : !z;
            step(1'b0, 3'd2, pk(0, 0, 0, 1, 0, e.ext, e.alu, e.src, {1'b0, taken}, 0, 0), "ex_br");
            n_ret++;
            return;
        end
        if (e.k == JR) begin
            step(1'b0, 3'd2, pk(0, 0, 0, 1, 0, e.ext, e.alu, e.src, 2'b11, 0, 0), "ex_jr");
            n_ret++;
            return;
        end
        if (e.k == JALR) begin
            step(1'b0, 3'd2, pk(0, 0, 0, 1, 1, e.ext, e.alu, e.src, 2'b11, 2'b00, 2'b10), "ex_jalr");
            n_ret++;
            return;
        end
        step(1'b0, 3'd2, pk(0, 0, 0, 0, 0, e.ext, e.alu, e.src, 0, 0, 0), "ex");

        if (e.k == LW || e.k == SW) begin
            if (abort_mem) begin
                do_reset(3'd3);
                return;
            end
            n_cyc = (d_mem < WMAX) ? d_mem + 1 : WMAX;
            for (int c = 0; c < n_cyc; c++) begin
                last = (d_mem < WMAX) && (c == d_mem);
                step(last, 3'd3, pk(1, is_sw, 0, is_sw && last, 0, e.ext, e.alu, e.src, 0, 0, 0),
                     "mem");
            end
            if (d_mem >= WMAX) begin
                err_hold(1'b0, 1'b1);
                return;
            end
            if (is_sw) begin
                n_ret++;
                return;
            end
        end

        gs = (e.k == I_ALU || e.k == LW) ? 2'b01 : 2'b00;
        ws = (e.k == LW) ? 2'b01 : 2'b00;
        step(1'b0, 3'd4, pk(0, 0, 0, 1, 1, e.ext, e.alu, e.src, 2'b00, gs, ws), "wb");
        n_ret++;
    endtask

    task automatic run_illegal(input logic [5:0] op, input logic [5:0] fn);
        cur_op = op; cur_fn = fn; cur_z = 1'b0;
        step(1'b1, 3'd0, pk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "if_bad");
        step(1'b0, 3'd1, 19'd0, "id_bad");
        err_hold(1'b1, 1'b0);
    endtask

    function automatic int rnd_wait();
        return ($urandom_range(0, 9) == 0) ? WMAX - 1 : int'($urandom_range(0, 3));
    endfunction

    initial begin
        rst = 1'b1; Op = '0; Funct = '0; Zero = 1'b0; mem_ack = 1'b0;
        add_ins(6'h00, 6'h20, R_ALU, 4'd1, 2'b00, 2'b00);
        add_ins(6'h00, 6'h21, R_ALU, 4'd1, 2'b00, 2'b00);
        add_ins(6'h00, 6'h22, R_ALU, 4'd2, 2'b00, 2'b00);
        add_ins(6'h00, 6'h23, R_ALU, 4'd2, 2'b00, 2'b00);
        add_ins(6'h00, 6'h24, R_ALU, 4'd3, 2'b00, 2'b00);
        add_ins(6'h00, 6'h25, R_ALU, 4'd4, 2'b00, 2'b00);
        add_ins(6'h00, 6'h27, R_ALU, 4'd7, 2'b00, 2'b00);
        add_ins(6'h00, 6'h2a, R_ALU, 4'd5, 2'b00, 2'b00);
        add_ins(6'h00, 6'h2b, R_ALU, 4'd6, 2'b00, 2'b00);
        add_ins(6'h00, 6'h00, R_ALU, 4'd8, 2'b01, 2'b00);
        add_ins(6'h00, 6'h02, R_ALU, 4'd9, 2'b01, 2'b00);
        add_ins(6'h00, 6'h04, R_ALU, 4'd8, 2'b00, 2'b00);
        add_ins(6'h00, 6'h06, R_ALU, 4'd9, 2'b00, 2'b00);
        add_ins(6'h00, 6'h08, JR,    4'd0, 2'b00, 2'b00);
        add_ins(6'h00, 6'h09, JALR,  4'd0, 2'b00, 2'b00);
        add_ins(6'h08, 6'h00, I_ALU, 4'd1, 2'b10, 2'b01);
        add_ins(6'h0c, 6'h00, I_ALU, 4'd3, 2'b10, 2'b00);
        add_ins(6'h0d, 6'h00, I_ALU, 4'd4, 2'b10, 2'b00);
        add_ins(6'h0a, 6'h00, I_ALU, 4'd5, 2'b10, 2'b01);
        add_ins(6'h0f, 6'h00, I_ALU, 4'd1, 2'b10, 2'b10);
        add_ins(6'h23, 6'h00, LW,    4'd1, 2'b10, 2'b01);
        add_ins(6'h2b, 6'h00, SW,    4'd1, 2'b10, 2'b01);
        add_ins(6'h04, 6'h00, BEQ,   4'd2, 2'b00, 2'b01);
        add_ins(6'h05, 6'h00, BNE,   4'd2, 2'b00, 2'b01);
        add_ins(6'h02, 6'h00, J,     4'd0, 2'b00, 2'b00);
        add_ins(6'h03, 6'h00, JAL,   4'd0, 2'b00, 2'b00);

        repeat (2) @(negedge clk);
        do_reset(3'd0);

        run_instr(IX_ADDI, 1'b0, 0, 0, 1'b0);
        run_instr(IX_LW,   1'b0, 0, 3, 1'b0);
        run_instr(IX_BEQ,  1'b1, 0, 0, 1'b0);
        run_instr(IX_BNE,  1'b1, 0, 0, 1'b0);
        run_instr(IX_BEQ,  1'b0, 1, 0, 1'b0);
        run_instr(IX_BNE,  1'b0, 0, 0, 1'b0);
        run_instr(IX_JAL,  1'b0, 0, 0, 1'b0);
        run_instr(IX_JALR, 1'b0, 0, 0, 1'b0);
        run_instr(IX_J,    1'b0, 2, 0, 1'b0);
        run_instr(IX_JR,   1'b0, 0, 0, 1'b0);
        run_instr(IX_ADD,  1'b0, WMAX - 1, 0, 1'b0);
        run_instr(IX_SW,   1'b0, 0, WMAX - 1, 1'b0);

        for (int i = 0; i < 200; i++)
            run_instr(int'($urandom_range(0, 25)), 1'($urandom_range(0, 1)),
                      rnd_wait(), rnd_wait(), 1'b0);

        run_instr(IX_SW, 1'b0, 1, 0, 1'b1);
        run_instr(IX_ADDI, 1'b0, 0, 0, 1'b0);

        run_illegal(6'h3f, 6'($urandom));
        do_reset(3'd5);
        run_illegal(6'h00, 6'h01);
        do_reset(3'd5);

        run_instr(IX_ADD, 1'b0, WMAX, 0, 1'b0);
        do_reset(3'd5);
        run_instr(IX_LW, 1'b0, 0, WMAX, 1'b0);
        do_reset(3'd5);

        run_instr(IX_ADDI, 1'b0, 0, 0, 1'b0);
        run_instr(IX_J,    1'b0, 0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
